icache_fill_ctrl: RTL
=====================

ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYC, 255, fill watchdog limit in cycles (used only with ICACHE_FILL_TIMEOUT_EN).
REQ-002 Port: CLK  in  1  sole clock, all state on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: miss_req  in  1  icache miss request, level, sampled only in IDLE.
REQ-005 Port: miss_addr  in  15  physical fetch address of the missing line.
REQ-006 Port: flush  in  1  abort outstanding fill (mispredict/CS invalidate/replay).
REQ-007 Port: bus_req  out  1  memory bus request, held until grant.
REQ-008 Port: bus_addr  out  15  line-aligned address, [3:0]=0.
REQ-009 Port: bus_gnt  in  1  bus grant, meaningful only while bus_req=1.
REQ-010 Port: bus_rdata  in  32  read beat data.
REQ-011 Port: bus_rvalid  in  1  read beat valid.
REQ-012 Port: fill_valid  out  1  one-cycle pulse, line ready for icache write.
REQ-013 Port: fill_addr  out  15  line-aligned address of filled line.
REQ-014 Port: fill_data  out  128  filled line, beat i in bits [32i+31:32i].
REQ-015 Port: busy  out  1  high whenever state is not IDLE.
REQ-016 Port: fill_error  out  1  one-cycle timeout pulse; constant 0 when feature compiled out.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DATA, DRAIN, DONE.
REQ-018 IDLE: miss_req=1 and flush=0 -> latch {miss_addr[14:4],4'h0}, go REQ; flush wins over simultaneous miss_req.
REQ-019 REQ: bus_req=1, bus_addr=latched address; bus_gnt=1 -> DATA with beat counter 0; flush=1 -> IDLE, bus_req drops next cycle.
REQ-020 DATA: each bus_rvalid writes bus_rdata into beat[counter], counter+1; 4th beat -> DONE.
REQ-021 DATA with flush=1 -> DRAIN; a beat valid in the same cycle counts toward the 4.
REQ-022 DRAIN: accept and discard remaining beats until 4 total, then IDLE; no fill_valid.
REQ-023 DONE: fill_valid=1 for exactly one cycle, then IDLE; flush=1 in DONE suppresses fill_valid.
REQ-024 bus_rvalid outside DATA/DRAIN SHALL be ignored; counter is 2 bits, wraps only on the 4th beat.
REQ-025 Best-case latency: miss_req cycle 0, bus_req cycle 1, gnt cycle 1, beats cycles 2-5, fill_valid cycle 6.
REQ-026 fill_addr/fill_data SHALL hold stable from DONE until the next fill's first beat.
REQ-027 miss_req while busy=1 SHALL be ignored; the icache re-presents it.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, counter 0, bus_req=0, fill_valid=0, fill_error=0, busy=0, fill_addr=0, fill_data=0.
REQ-029 Reset mid-fill SHALL abandon the transfer; beats arriving after reset release are ignored.

Configuration
REQ-030 Macro ICACHE_FILL_TIMEOUT_EN SHALL compile in an 8-bit watchdog cleared on entry to REQ and on every accepted beat.
REQ-031 With the macro: counter reaching TIMEOUT_CYC in REQ/DATA/DRAIN -> IDLE, fill_error pulses one cycle, no fill_valid.
REQ-032 Without the macro: no watchdog logic, fill_error tied 0, a fill waits indefinitely.

Structure
REQ-033 Shared header icache_defs.vh SHALL hold state encodings, LINE_BITS=128, BEAT_BITS=32, BEATS=4.
REQ-034 Line storage SHALL be sub-module fill_line_buf (4x32 registers, per-beat write enable, async reset).

Verification
REQ-035 miss_req, addr 0x1234, gnt same cycle, beats A0..A3 back-to-back -> bus_addr 0x1230, fill_valid cycle 6, fill_data {A3,A2,A1,A0}.
REQ-036 gnt delayed 5 cycles, one idle gap between beats -> bus_req held 5 cycles, single fill_valid after 4th beat.
REQ-037 flush in REQ before gnt -> bus_req low next cycle, busy low, no fill_valid.
REQ-038 flush after beat 2 -> DRAIN consumes beats 3-4, no fill_valid, busy low after 4th beat.
REQ-039 reset asserted after beat 1 -> all outputs 0 immediately; next miss fills correctly.
REQ-040 ICACHE_FILL_TIMEOUT_EN, TIMEOUT_CYC=16, gnt never asserted -> fill_error pulse at cycle 17, state IDLE.

Source files
------------

// File: rtl/icache_fill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_fill_ctrl_pkg
// Brief    : Shared line/beat geometry and fill FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package icache_fill_ctrl_pkg;

    localparam int LINE_BITS = 128;
    localparam int BEAT_BITS = 32;
    localparam int BEATS     = 4;
    localparam int ADDR_BITS = 15;
    localparam int CNT_BITS  = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DATA  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } fill_state_e;

endpackage
`default_nettype wire

// File: rtl/icache_fill_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_fill_ctrl_if
// Brief    : Miss request, memory bus and line fill signals of the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface icache_fill_ctrl_if;
    import icache_fill_ctrl_pkg::*;

    logic                 miss_req;
    logic [ADDR_BITS-1:0] miss_addr;
    logic                 flush;
    logic                 bus_req;
    logic [ADDR_BITS-1:0] bus_addr;
    logic                 bus_gnt;
    logic [BEAT_BITS-1:0] bus_rdata;
    logic                 bus_rvalid;
    logic                 fill_valid;
    logic [ADDR_BITS-1:0] fill_addr;
    logic [LINE_BITS-1:0] fill_data;
    logic                 busy;
    logic                 fill_error;

    modport master (
        input  miss_req, miss_addr, flush, bus_gnt, bus_rdata, bus_rvalid,
        output bus_req, bus_addr, fill_valid, fill_addr, fill_data, busy, fill_error
    );

    modport slave (
        output miss_req, miss_addr, flush, bus_gnt, bus_rdata, bus_rvalid,
        input  bus_req, bus_addr, fill_valid, fill_addr, fill_data, busy, fill_error
    );

endinterface
`default_nettype wire

// File: rtl/icache_fill_ctrl_line_buf.sv
`default_nettype none
// ============================================================================
// Module   : fill_line_buf
// Brief    : Line assembly registers, one beat-wide register per beat slot.
// Revision : 1.0 - initial release
// ============================================================================
module fill_line_buf
    import icache_fill_ctrl_pkg::*;
#(
    parameter int N_BEATS  = BEATS,
    parameter int W_BEAT   = BEAT_BITS,
    parameter int IDX_BITS = $clog2(N_BEATS)
) (
    input  wire logic                        CLK,
    input  wire logic                        reset,
    input  wire logic                        we,
    input  wire logic [IDX_BITS-1:0]         idx,
    input  wire logic [W_BEAT-1:0]           wdata,
    output logic      [N_BEATS*W_BEAT-1:0]   line
);

    for (genvar gi = 0; gi < N_BEATS; gi++) begin : g_beat
        logic [W_BEAT-1:0] r_beat;

        always_ff @(posedge CLK or negedge reset) begin
            if (!reset) begin
                r_beat <= '0;
            end else if (we && (idx == IDX_BITS'(gi))) begin
                r_beat <= wdata;
            end
        end

        assign line[gi*W_BEAT +: W_BEAT] = r_beat;
    end

endmodule
`default_nettype wire

// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_fill_ctrl
// Brief    : Instruction-cache line fill controller (4-beat bus burst).
//            ICACHE_FILL_TIMEOUT_EN adds a fill watchdog raising fill_error.
// Revision : 1.0 - initial release
// ============================================================================
module icache_fill_ctrl
    import icache_fill_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  wire logic           CLK,
    input  wire logic           reset,
    icache_fill_ctrl_if.master  ctl
);

    fill_state_e          r_state;
    fill_state_e          w_state_nxt;
    logic [CNT_BITS-1:0]  r_beat_cnt;
    logic [ADDR_BITS-1:0] r_req_addr;
    logic [ADDR_BITS-1:0] r_fill_addr;
    logic [LINE_BITS-1:0] w_line;
    logic                 w_beat_acc;
    logic                 w_beat_wr;
    logic                 w_last_beat;
    logic                 w_timeout;
    logic [3:0]           w_unused_offset;

    assign w_unused_offset = ctl.miss_addr[3:0];

    // Beats count in DATA and DRAIN, but only DATA beats land in the line.
    assign w_beat_acc  = ctl.bus_rvalid && ((r_state == DATA) || (r_state == DRAIN));
    assign w_beat_wr   = ctl.bus_rvalid && (r_state == DATA);
    assign w_last_beat = w_beat_acc && (r_beat_cnt == CNT_BITS'(BEATS - 1));

`ifdef ICACHE_FILL_TIMEOUT_EN
    logic [7:0] r_wdog;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_wdog <= '0;
        end else if ((r_state == IDLE) || w_beat_acc) begin
            r_wdog <= '0;
        end else if (r_state != DONE) begin
            r_wdog <= r_wdog + 8'd1;
        end
    end

    assign w_timeout = ((r_state == REQ) || (r_state == DATA) || (r_state == DRAIN))
                       && (r_wdog == 8'(TIMEOUT_CYC));
`else
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        ctl.bus_req    = 1'b0;
        ctl.fill_valid = 1'b0;
        ctl.busy       = (r_state != IDLE);
        ctl.fill_error = w_timeout;
        case (r_state)
            IDLE: begin
                if (ctl.miss_req && !ctl.flush) w_state_nxt = REQ;
            end
            REQ: begin
                ctl.bus_req = 1'b1;
                if (ctl.flush)        w_state_nxt = IDLE;
                else if (ctl.bus_gnt) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_last_beat)    w_state_nxt = ctl.flush ? IDLE : DONE;
                else if (ctl.flush) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_last_beat) w_state_nxt = IDLE;
            end
            DONE: begin
                ctl.fill_valid = !ctl.flush;
                w_state_nxt    = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_timeout) w_state_nxt = IDLE;
    end

    // fill_addr moves only on a new fill's first beat, in step with fill_data.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_beat_cnt  <= '0;
            r_req_addr  <= '0;
            r_fill_addr <= '0;
        end else begin
            if ((r_state == IDLE) && (w_state_nxt == REQ)) begin
                r_req_addr <= {ctl.miss_addr[ADDR_BITS-1:4], 4'h0};
            end
            if (r_state == REQ) begin
                r_beat_cnt <= '0;
            end else if (w_beat_acc) begin
                r_beat_cnt <= r_beat_cnt + CNT_BITS'(1);
            end
            if (w_beat_wr && (r_beat_cnt == '0)) begin
                r_fill_addr <= r_req_addr;
            end
        end
    end

    fill_line_buf #(
        .N_BEATS (BEATS),
        .W_BEAT  (BEAT_BITS)
    ) u_line_buf (
        .CLK   (CLK),
        .reset (reset),
        .we    (w_beat_wr),
        .idx   (r_beat_cnt),
        .wdata (ctl.bus_rdata),
        .line  (w_line)
    );

    assign ctl.bus_addr  = r_req_addr;
    assign ctl.fill_addr = r_fill_addr;
    assign ctl.fill_data = w_line;

endmodule
`default_nettype wire
